load_store_unit: RTL and testbench
==================================

Name: load_store_unit

Overview:
Multi-cycle data-memory interface for the RV32I core. It sits directly upstream of the writeback result mux and drives that mux's data-memory input with aligned, sign- or zero-extended load data. It converts core load/store requests into a word-aligned req/gnt/rvalid memory transaction with byte strobes. It holds the core with a stall until each access completes, errors, or times out.

Parameters:
TIMEOUT_CYCLES, 255, cycles spent in REQ+WAIT before an access is aborted with bus_err_o (range 1..65535)

Ports:
clk_i  in  1  clock, rising edge
rst_i  in  1  synchronous active-high reset
req_i  in  1  core requests a memory access; held stable while stall_o=1
we_i  in  1  1=store, 0=load
funct3_i  in  3  RV32I width/sign field
addr_i  in  32  byte address (ALU result)
wdata_i  in  32  store data (rs2)
rdata_o  out  32  formatted load data, to result mux data input
stall_o  out  1  core must not advance
misaligned_o  out  1  one-cycle pulse: misaligned or illegal access, no bus transaction
bus_err_o  out  1  one-cycle pulse in DONE after timeout
mem_req_o  out  1  memory request
mem_we_o  out  1  memory write enable
mem_addr_o  out  32  word address, {addr[31:2],2'b00}
mem_wstrb_o  out  4  byte write strobes (0000 on loads)
mem_wdata_o  out  32  lane-replicated store data
mem_gnt_i  in  1  memory accepted request
mem_rvalid_i  in  1  load data valid
mem_rdata_i  in  32  load data word

Behaviour:
- Reset (clk_i edge with rst_i=1): state=IDLE, timeout counter=0, all registered outputs 0 (rdata_o=0, misaligned_o=0, bus_err_o=0). mem_* outputs decode from state, so they are 0 in the cycle after reset. Reset aborts any access in flight. An mem_rvalid_i/mem_gnt_i arriving after reset is ignored.
- States:
  - IDLE: if req_i and access is legal, latch addr/we/funct3/wdata and go to REQ. stall_o=req_i&&legal (combinational).
  - REQ: mem_req_o=1, stall_o=1.
    - mem_gnt_i with store: go to DONE.
    - mem_gnt_i with load: go to WAIT.
    - mem_gnt_i and mem_rvalid_i in the same cycle for a load: capture data and go directly to DONE.
  - WAIT: stall_o=1. mem_rvalid_i captures formatted data into rdata_o and goes to DONE.
  - DONE: stall_o=0; the core advances on this edge. Go to IDLE unconditionally; req_i in DONE belongs to the finished instruction.
- Legality:
  - Loads: funct3 in {000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU}.
  - Stores: funct3 in {000 SB, 001 SH, 010 SW}.
  - Halfword requires addr[0]=0. Word requires addr[1:0]=00.
  - Illegal or misaligned access in IDLE: no bus request, stall_o=0, misaligned_o=1 on the next cycle for one cycle, rdata_o unchanged.
- Store formatting (addr[1:0]=o):
  - SB: strobe 0001<<o, data = byte replicated x4.
  - SH: strobe 0011<<o, data = halfword replicated x2.
  - SW: strobe 1111, data = wdata_i.
- Load formatting: lane = mem_rdata_i >> (8*o).
  - LB/LH: sign-extend bit 7/15.
  - LBU/LHU: zero-extend.
  - LW: whole word.
- rdata_o holds its value until the next load completes or a timeout occurs. Stores do not change rdata_o.
- Timeout:
  - Counter clears on entry to REQ and increments each cycle in REQ/WAIT.
  - When the counter equals TIMEOUT_CYCLES-1 with no completing event: go to DONE, rdata_o=0 for loads, bus_err_o=1 during DONE.
  - A completing event in the same cycle as the timeout wins (no error).
- mem_addr_o/mem_we_o/mem_wstrb_o/mem_wdata_o are valid only while mem_req_o=1. They are 0 otherwise.

Test Plan:
- SW addr=0x100, wdata=0xDEADBEEF, gnt on first REQ cycle -> mem_addr=0x100, wstrb=1111, wdata=0xDEADBEEF; stall_o high 2 cycles (IDLE,REQ), low in DONE.
- SB addr=0x103, wdata=0x000000A5 -> wstrb=1000, mem_wdata=0xA5A5A5A5, mem_addr=0x100.
- mem word 0x8001F0FF. LB addr+1 -> 0xFFFFFFF0. LBU addr+1 -> 0x000000F0. LH addr+2 -> 0xFFFF8001. LHU addr+2 -> 0x00008001. Each with gnt then rvalid 3 cycles later; rdata_o valid in DONE.
- LW addr=0x102 -> misaligned_o pulse, mem_req_o never asserted, stall_o=0, rdata_o unchanged. funct3=011 -> same response.
- TIMEOUT_CYCLES=4, load with mem_gnt_i=0 forever -> after 4 REQ cycles: DONE, bus_err_o=1 one cycle, rdata_o=0. Repeat with gnt+rvalid on the 4th cycle -> no error, data captured.
- Load granted, rst_i asserted in WAIT, then a late mem_rvalid_i -> state IDLE, rdata_o=0, stall_o=0, late data ignored.

Source files
------------

// File: rtl/load_store_unit.sv
// RV32I data-memory interface: turns core load/store requests into a req/gnt/rvalid
// word transaction with byte strobes, formats load data and stalls the core until done.
module load_store_unit #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req_i,
  input  logic        we_i,
  input  logic [2:0]  funct3_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] rdata_o,
  output logic        stall_o,
  output logic        misaligned_o,
  output logic        bus_err_o,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [31:0] mem_addr_o,
  output logic [3:0]  mem_wstrb_o,
  output logic [31:0] mem_wdata_o,
  input  logic        mem_gnt_i,
  input  logic        mem_rvalid_i,
  input  logic [31:0] mem_rdata_i
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

  localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT_CYCLES - 1);

  state_t      state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic        we_q, we_d;
  logic [2:0]  funct3_q, funct3_d;
  logic [31:0] wdata_q, wdata_d;
  logic [15:0] cnt_q, cnt_d;
  logic [31:0] rdata_q, rdata_d;
  logic        misaligned_q, misaligned_d;
  logic        bus_err_q, bus_err_d;
  logic        timeout;

  function automatic logic access_legal(input logic we, input logic [2:0] f3,
                                        input logic [1:0] off);
    logic ok;
    case (f3)
      3'b000:  ok = 1'b1;
      3'b001:  ok = ~off[0];
      3'b010:  ok = (off == 2'b00);
      3'b100:  ok = ~we;
      3'b101:  ok = ~we & ~off[0];
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

  function automatic logic [31:0] format_load(input logic [2:0] f3, input logic [1:0] off,
                                              input logic [31:0] word);
    logic [31:0] lane;
    logic [31:0] res;
    lane = word >> {off, 3'b000};
    case (f3)
      3'b000:  res = {{24{lane[7]}}, lane[7:0]};
      3'b001:  res = {{16{lane[15]}}, lane[15:0]};
      3'b100:  res = {24'h0, lane[7:0]};
      3'b101:  res = {16'h0, lane[15:0]};
      default: res = lane;
    endcase
    return res;
  endfunction

  assign timeout = (cnt_q == TIMEOUT_LAST);

  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    we_d         = we_q;
    funct3_d     = funct3_q;
    wdata_d      = wdata_q;
    cnt_d        = cnt_q;
    rdata_d      = rdata_q;
    misaligned_d = 1'b0;
    bus_err_d    = 1'b0;
    stall_o      = 1'b0;
    mem_req_o    = 1'b0;
    mem_we_o     = 1'b0;
    mem_addr_o   = 32'h0;
    mem_wstrb_o  = 4'b0000;
    mem_wdata_o  = 32'h0;

    case (state_q)
      IDLE: begin
        if (req_i) begin
          if (access_legal(we_i, funct3_i, addr_i[1:0])) begin
            stall_o  = 1'b1;
            addr_d   = addr_i;
            we_d     = we_i;
            funct3_d = funct3_i;
            wdata_d  = wdata_i;
            cnt_d    = 16'h0;
            state_d  = REQ;
          end else begin
            misaligned_d = 1'b1;
          end
        end
      end

      REQ: begin
        stall_o    = 1'b1;
        mem_req_o  = 1'b1;
        mem_we_o   = we_q;
        mem_addr_o = {addr_q[31:2], 2'b00};
        if (we_q) begin
          case (funct3_q[1:0])
            2'b00: begin
              mem_wstrb_o = 4'b0001 << addr_q[1:0];
              mem_wdata_o = {4{wdata_q[7:0]}};
            end
            2'b01: begin
              mem_wstrb_o = 4'b0011 << addr_q[1:0];
              mem_wdata_o = {2{wdata_q[15:0]}};
            end
            default: begin
              mem_wstrb_o = 4'b1111;
              mem_wdata_o = wdata_q;
            end
          endcase
        end
        cnt_d = cnt_q + 16'd1;
        // Completion is checked before timeout so a same-cycle response wins.
        if (mem_gnt_i && we_q) begin
          state_d = DONE;
        end else if (mem_gnt_i && mem_rvalid_i) begin
          rdata_d = format_load(funct3_q, addr_q[1:0], mem_rdata_i);
          state_d = DONE;
        end else if (timeout) begin
          bus_err_d = 1'b1;
          if (!we_q) rdata_d = 32'h0;
          state_d = DONE;
        end else if (mem_gnt_i) begin
          state_d = WAIT;
        end
      end

      WAIT: begin
        stall_o = 1'b1;
        cnt_d   = cnt_q + 16'd1;
        if (mem_rvalid_i) begin
          rdata_d = format_load(funct3_q, addr_q[1:0], mem_rdata_i);
          state_d = DONE;
        end else if (timeout) begin
          bus_err_d = 1'b1;
          rdata_d   = 32'h0;
          state_d   = DONE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= IDLE;
      addr_q       <= 32'h0;
      we_q         <= 1'b0;
      funct3_q     <= 3'b000;
      wdata_q      <= 32'h0;
      cnt_q        <= 16'h0;
      rdata_q      <= 32'h0;
      misaligned_q <= 1'b0;
      bus_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      we_q         <= we_d;
      funct3_q     <= funct3_d;
      wdata_q      <= wdata_d;
      cnt_q        <= cnt_d;
      rdata_q      <= rdata_d;
      misaligned_q <= misaligned_d;
      bus_err_q    <= bus_err_d;
    end
  end

  assign rdata_o      = rdata_q;
  assign misaligned_o = misaligned_q;
  assign bus_err_o    = bus_err_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: one default-timeout instance for normal traffic
// and reset abort, plus a TIMEOUT_CYCLES=4 instance for the timeout boundary.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req = 1'b0;
  logic        we = 1'b0;
  logic [2:0]  funct3 = 3'b000;
  logic [31:0] addr = 32'h0;
  logic [31:0] wdata = 32'h0;
  logic        mem_gnt = 1'b0;
  logic        mem_rvalid = 1'b0;
  logic [31:0] mem_rdata = 32'h0;

  logic [31:0] rdata_a, mem_addr_a, mem_wdata_a;
  logic        stall_a, misal_a, berr_a, mem_req_a, mem_we_a;
  logic [3:0]  mem_wstrb_a;
  logic [31:0] rdata_b, mem_addr_b, mem_wdata_b;
  logic        stall_b, misal_b, berr_b, mem_req_b, mem_we_b;
  logic [3:0]  mem_wstrb_b;

  int tests_run = 0;
  int tests_failed = 0;

  load_store_unit dut (
    .clk_i(clk), .rst_i(rst), .req_i(req), .we_i(we), .funct3_i(funct3),
    .addr_i(addr), .wdata_i(wdata), .rdata_o(rdata_a), .stall_o(stall_a),
    .misaligned_o(misal_a), .bus_err_o(berr_a), .mem_req_o(mem_req_a),
    .mem_we_o(mem_we_a), .mem_addr_o(mem_addr_a), .mem_wstrb_o(mem_wstrb_a),
    .mem_wdata_o(mem_wdata_a), .mem_gnt_i(mem_gnt), .mem_rvalid_i(mem_rvalid),
    .mem_rdata_i(mem_rdata)
  );

  load_store_unit #(.TIMEOUT_CYCLES(4)) dut_to (
    .clk_i(clk), .rst_i(rst), .req_i(req), .we_i(we), .funct3_i(funct3),
    .addr_i(addr), .wdata_i(wdata), .rdata_o(rdata_b), .stall_o(stall_b),
    .misaligned_o(misal_b), .bus_err_o(berr_b), .mem_req_o(mem_req_b),
    .mem_we_o(mem_we_b), .mem_addr_o(mem_addr_b), .mem_wstrb_o(mem_wstrb_b),
    .mem_wdata_o(mem_wdata_b), .mem_gnt_i(mem_gnt), .mem_rvalid_i(mem_rvalid),
    .mem_rdata_i(mem_rdata)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    tests_run++;
    if (observed !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic r, input logic w, input logic [2:0] f3,
                               input logic [31:0] a, input logic [31:0] d);
    req = r; we = w; funct3 = f3; addr = a; wdata = d;
  endtask

  task automatic nextCycle();
    @(posedge clk); #1;
  endtask

  task automatic resetAll();
    applyStimulus(1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
    mem_gnt = 1'b0; mem_rvalid = 1'b0;
    rst = 1'b1;
    nextCycle(); nextCycle();
    rst = 1'b0;
  endtask

  // Load on the default instance: gnt in the first REQ cycle, rvalid lat cycles later.
  task automatic runLoad(input string tag, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] word, input int lat, input logic [31:0] exp_data);
    applyStimulus(1'b1, 1'b0, f3, a, 32'h0);
    @(negedge clk); checkOutput({tag, "_idle_stall"}, 32'(stall_a), 32'd1);
    nextCycle();
    mem_gnt = 1'b1; mem_rvalid = (lat == 0); mem_rdata = word;
    @(negedge clk); checkOutput({tag, "_req_wstrb"}, 32'(mem_wstrb_a), 32'h0);
    nextCycle();
    mem_gnt = 1'b0; mem_rvalid = 1'b0;
    if (lat > 0) begin
      for (int i = 1; i < lat; i++) nextCycle();
      mem_rvalid = 1'b1;
      nextCycle();
      mem_rvalid = 1'b0;
    end
    @(negedge clk);
    checkOutput({tag, "_data"}, rdata_a, exp_data);
    checkOutput({tag, "_done_stall"}, 32'(stall_a), 32'd0);
    req = 1'b0;
    nextCycle();
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    resetAll();
    @(negedge clk);
    checkOutput("rst_rdata", rdata_a, 32'h0);
    checkOutput("rst_stall", 32'(stall_a), 32'd0);
    checkOutput("rst_mem_req", 32'(mem_req_a), 32'd0);
    checkOutput("rst_flags", {30'h0, misal_a, berr_a}, 32'h0);
    nextCycle();

    // SW, granted in the first REQ cycle
    applyStimulus(1'b1, 1'b1, 3'b010, 32'h100, 32'hDEADBEEF);
    @(negedge clk); checkOutput("sw_idle_stall", 32'(stall_a), 32'd1);
    nextCycle(); mem_gnt = 1'b1;
    @(negedge clk);
    checkOutput("sw_req", 32'(mem_req_a), 32'd1);
    checkOutput("sw_we", 32'(mem_we_a), 32'd1);
    checkOutput("sw_addr", mem_addr_a, 32'h100);
    checkOutput("sw_wstrb", 32'(mem_wstrb_a), 32'hF);
    checkOutput("sw_wdata", mem_wdata_a, 32'hDEADBEEF);
    checkOutput("sw_req_stall", 32'(stall_a), 32'd1);
    nextCycle(); mem_gnt = 1'b0;
    @(negedge clk);
    checkOutput("sw_done_stall", 32'(stall_a), 32'd0);
    checkOutput("sw_done_mem_req", 32'(mem_req_a), 32'd0);
    checkOutput("sw_done_wstrb", 32'(mem_wstrb_a), 32'h0);
    req = 1'b0; nextCycle();

    // SB to the top byte lane
    applyStimulus(1'b1, 1'b1, 3'b000, 32'h103, 32'h000000A5);
    nextCycle(); mem_gnt = 1'b1;
    @(negedge clk);
    checkOutput("sb_addr", mem_addr_a, 32'h100);
    checkOutput("sb_wstrb", 32'(mem_wstrb_a), 32'h8);
    checkOutput("sb_wdata", mem_wdata_a, 32'hA5A5A5A5);
    nextCycle(); mem_gnt = 1'b0; req = 1'b0; nextCycle();

    // SH upper half
    applyStimulus(1'b1, 1'b1, 3'b001, 32'h202, 32'h00001234);
    nextCycle(); mem_gnt = 1'b1;
    @(negedge clk);
    checkOutput("sh_wstrb", 32'(mem_wstrb_a), 32'hC);
    checkOutput("sh_wdata", mem_wdata_a, 32'h12341234);
    nextCycle(); mem_gnt = 1'b0; req = 1'b0; nextCycle();
    checkOutput("store_keeps_rdata", rdata_a, 32'h0);

    runLoad("lb", 3'b000, 32'h201, 32'h8001F0FF, 3, 32'hFFFFFFF0);
    runLoad("lbu", 3'b100, 32'h201, 32'h8001F0FF, 3, 32'h000000F0);
    runLoad("lh", 3'b001, 32'h202, 32'h8001F0FF, 3, 32'hFFFF8001);
    runLoad("lhu", 3'b101, 32'h202, 32'h8001F0FF, 3, 32'h00008001);
    runLoad("lw_fast", 3'b010, 32'h204, 32'h13572468, 0, 32'h13572468);
    runLoad("lb0", 3'b000, 32'h200, 32'h0000007F, 1, 32'h0000007F);

    // Misaligned LW, then illegal funct3: no bus activity, rdata kept
    applyStimulus(1'b1, 1'b0, 3'b010, 32'h102, 32'h0);
    @(negedge clk);
    checkOutput("mis_stall", 32'(stall_a), 32'd0);
    checkOutput("mis_mem_req", 32'(mem_req_a), 32'd0);
    nextCycle(); req = 1'b0;
    @(negedge clk);
    checkOutput("mis_pulse", 32'(misal_a), 32'd1);
    checkOutput("mis_mem_req2", 32'(mem_req_a), 32'd0);
    checkOutput("mis_rdata", rdata_a, 32'h0000007F);
    nextCycle();
    @(negedge clk); checkOutput("mis_pulse_end", 32'(misal_a), 32'd0);
    applyStimulus(1'b1, 1'b0, 3'b011, 32'h100, 32'h0);
    @(negedge clk); checkOutput("ill_stall", 32'(stall_a), 32'd0);
    nextCycle(); req = 1'b0;
    @(negedge clk);
    checkOutput("ill_pulse", 32'(misal_a), 32'd1);
    checkOutput("ill_mem_req", 32'(mem_req_a), 32'd0);
    checkOutput("ill_rdata", rdata_a, 32'h0000007F);
    nextCycle();

    // TIMEOUT_CYCLES=4: completion in the 4th REQ cycle beats the timeout
    resetAll();
    applyStimulus(1'b1, 1'b0, 3'b010, 32'h200, 32'h0);
    nextCycle();
    for (int i = 0; i < 3; i++) nextCycle();
    @(negedge clk); checkOutput("to_win_still_req", 32'(mem_req_b), 32'd1);
    mem_gnt = 1'b1; mem_rvalid = 1'b1; mem_rdata = 32'h8001F0FF;
    nextCycle(); mem_gnt = 1'b0; mem_rvalid = 1'b0;
    @(negedge clk);
    checkOutput("to_win_berr", 32'(berr_b), 32'd0);
    checkOutput("to_win_data", rdata_b, 32'h8001F0FF);
    checkOutput("to_win_stall", 32'(stall_b), 32'd0);
    req = 1'b0; nextCycle();

    // Never granted: abort after 4 REQ cycles
    applyStimulus(1'b1, 1'b0, 3'b010, 32'h204, 32'h0);
    nextCycle();
    for (int i = 0; i < 3; i++) nextCycle();
    @(negedge clk);
    checkOutput("to_req_stall", 32'(stall_b), 32'd1);
    checkOutput("to_no_err_yet", 32'(berr_b), 32'd0);
    nextCycle();
    @(negedge clk);
    checkOutput("to_berr", 32'(berr_b), 32'd1);
    checkOutput("to_rdata", rdata_b, 32'h0);
    checkOutput("to_stall", 32'(stall_b), 32'd0);
    checkOutput("to_mem_req", 32'(mem_req_b), 32'd0);
    req = 1'b0; nextCycle();
    @(negedge clk); checkOutput("to_berr_end", 32'(berr_b), 32'd0);

    // Reset while waiting for load data; the late rvalid must be ignored
    resetAll();
    runLoad("pre_rst", 3'b010, 32'h300, 32'h12345678, 1, 32'h12345678);
    applyStimulus(1'b1, 1'b0, 3'b010, 32'h304, 32'h0);
    nextCycle(); mem_gnt = 1'b1;
    nextCycle(); mem_gnt = 1'b0;
    @(negedge clk); checkOutput("rst_wait_stall", 32'(stall_a), 32'd1);
    rst = 1'b1; req = 1'b0;
    nextCycle();
    rst = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'hCAFEBABE;
    nextCycle(); mem_rvalid = 1'b0;
    @(negedge clk);
    checkOutput("rst_abort_rdata", rdata_a, 32'h0);
    checkOutput("rst_abort_stall", 32'(stall_a), 32'd0);
    checkOutput("rst_abort_mem_req", 32'(mem_req_a), 32'd0);
    nextCycle();
    @(negedge clk); checkOutput("rst_late_ignored", rdata_a, 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
